wb_port_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between two requesters.
- Requester 1 is the in-order pipeline writeback stage. Its data is selected in-block from PC+4, ALU result or DM read data.
- Requester 2 is a long-latency unit (mul/div) returning results through a valid/ready handshake.
- MDU results are buffered in a small FIFO. A starvation counter stalls the pipeline so buffered results are guaranteed to drain.

---
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB stage vs. buffered MDU results.
// Optional: define WB_X0_FILTER_EN to suppress rf_we for writes to x0.
module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_waddr,
    input  logic [1:0]  pipe_wbsel,
    input  logic [31:0] pipe_pc,
    input  logic [31:0] pipe_alu,
    input  logic [31:0] pipe_dm,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_waddr,
    input  logic [31:0] mdu_wdata,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_e;

    state_e            state_q, state_d;
    logic [4:0]        fifo_addr_q [DEPTH];
    logic [31:0]       fifo_data_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;

    logic              fifo_empty, fifo_full, push, pop;
    logic              grant_pipe, grant_fifo;
    logic [31:0]       pipe_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign mdu_ready  = !fifo_full;
    assign push       = mdu_valid && mdu_ready;
    assign pop        = grant_fifo;
    assign pipe_stall = (state_q == ST_FORCE);

    always_comb begin
        case (pipe_wbsel)
            2'd0:    pipe_data = pipe_pc + 32'd4;
            2'd1:    pipe_data = pipe_alu;
            2'd2:    pipe_data = pipe_dm;
            default: pipe_data = '0;
        endcase
    end

    always_comb begin
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
        state_d    = ST_NORMAL;
        wait_d     = '0;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (state_q == ST_FORCE) begin
            grant_fifo = !fifo_empty;
        end else if (pipe_valid) begin
            grant_pipe = 1'b1;
        end else begin
            grant_fifo = !fifo_empty;
        end

        if (grant_pipe) begin
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_data;
        end else if (grant_fifo) begin
            rf_waddr_d = fifo_addr_q[rd_ptr_q];
            rf_wdata_d = fifo_data_q[rd_ptr_q];
        end
`ifdef WB_X0_FILTER_EN
        rf_we_d = (grant_pipe || grant_fifo) && (rf_waddr_d != '0);
`else
        rf_we_d = grant_pipe || grant_fifo;
`endif

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Starvation is judged on the pre-push occupancy of this cycle.
        if (fifo_empty || grant_fifo) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end

        if (state_q == ST_NORMAL && wait_d == WAIT_MAX) begin
            state_d = ST_FORCE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_NORMAL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mdu_waddr;
            fifo_data_q[wr_ptr_q] <= mdu_wdata;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model plus directed scenarios.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef WB_X0_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk, rst;
    logic        pipe_valid;
    logic [4:0]  pipe_waddr;
    logic [1:0]  pipe_wbsel;
    logic [31:0] pipe_pc, pipe_alu, pipe_dm;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wbsel(pipe_wbsel),
        .pipe_pc(pipe_pc), .pipe_alu(pipe_alu), .pipe_dm(pipe_dm),
        .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference model: queue of pending MDU results and a starvation count.
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    int          m_wait;
    bit          m_force;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    function automatic logic [31:0] sel_data(logic [1:0] s, logic [31:0] pc,
                                             logic [31:0] alu, logic [31:0] dm);
        case (s)
            2'd0:    return pc + 32'd4;
            2'd1:    return alu;
            2'd2:    return dm;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait  = 0;
        m_force = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    task automatic model_update();
        int n;
        bit gp, gf;
        if (rst) return;
        n  = mq.size();
        gp = !m_force && pipe_valid;
        gf = (n > 0) && (m_force || !pipe_valid);
        if (gp) begin
            e_addr = pipe_waddr;
            e_data = sel_data(pipe_wbsel, pipe_pc, pipe_alu, pipe_dm);
        end else if (gf) begin
            e_addr = mq[0].a;
            e_data = mq[0].d;
        end
        e_we = (gp || gf) && !(FILTER && e_addr == 5'd0);
        if (gf) void'(mq.pop_front());
        if (mdu_valid && n < DEPTH) mq.push_back('{a: mdu_waddr, d: mdu_wdata});
        if (n == 0 || gf) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        m_force = !m_force && (m_wait == MAX_WAIT);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rf_we",    32'(rf_we),      32'(e_we));
            chk("rf_waddr", 32'(rf_waddr),   32'(e_addr));
            chk("rf_wdata", rf_wdata,        e_data);
            chk("stall",    32'(pipe_stall), 32'(m_force));
            chk("ready",    32'(mdu_ready),  32'(mq.size() < DEPTH));
        end
    end

    int          nstall;
    logic [4:0]  wlog[$];

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (rf_we) wlog.push_back(rf_waddr);
        if (pipe_stall) nstall++;
    endtask

    task automatic set_pipe(bit v, logic [4:0] a, logic [1:0] s,
                            logic [31:0] pc, logic [31:0] alu, logic [31:0] dm);
        pipe_valid = v; pipe_waddr = a; pipe_wbsel = s;
        pipe_pc = pc; pipe_alu = alu; pipe_dm = dm;
    endtask

    task automatic set_mdu(bit v, logic [4:0] a, logic [31:0] d);
        mdu_valid = v; mdu_waddr = a; mdu_wdata = d;
    endtask

    initial begin
        logic [4:0] mdu_seen[$];
        int hits;
        rst = 1'b1;
        set_pipe(0, '0, '0, '0, '0, '0);
        set_mdu(0, '0, '0);
        model_reset();
        #2;
        chk("rst_we",    32'(rf_we),      32'd0);
        chk("rst_waddr", 32'(rf_waddr),   32'd0);
        chk("rst_wdata", rf_wdata,        32'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("ready_after_rst", 32'(mdu_ready), 32'd1);

        // Pipe data select
        set_pipe(1, 5'd5, 2'd0, 32'h100, '0, '0);
        tick();
        chk("pc4_we", 32'(rf_we), 32'd1);
        chk("pc4_addr", 32'(rf_waddr), 32'd5);
        chk("pc4_data", rf_wdata, 32'h104);
        chk("pc4_stall", 32'(pipe_stall), 32'd0);
        set_pipe(1, 5'd6, 2'd0, 32'hFFFF_FFFC, '0, '0);
        tick();
        chk("pcwrap_data", rf_wdata, 32'h0);
        set_pipe(1, 5'd9, 2'd2, '0, 32'h1, 32'hCAFE_0001);
        tick();
        chk("dm_data", rf_wdata, 32'hCAFE_0001);
        set_pipe(1, 5'd10, 2'd3, 32'h5, 32'h6, 32'h7);
        tick();
        chk("zero_data", rf_wdata, 32'h0);
        set_pipe(0, '0, '0, '0, '0, '0);
        tick();
        chk("idle_we", 32'(rf_we), 32'd0);
        chk("idle_hold", 32'(rf_waddr), 32'd10);

        // Single MDU result, two-edge latency
        set_mdu(1, 5'd7, 32'hDEAD_BEEF);
        tick();
        set_mdu(0, '0, '0);
        chk("mdu_lat1_we", 32'(rf_we), 32'd0);
        tick();
        chk("mdu_we", 32'(rf_we), 32'd1);
        chk("mdu_addr", 32'(rf_waddr), 32'd7);
        chk("mdu_data", rf_wdata, 32'hDEAD_BEEF);
        tick();
        chk("mdu_drained_we", 32'(rf_we), 32'd0);

        // Starvation with the pipe hogging the port
        set_pipe(1, 5'd3, 2'd1, '0, 32'h11, '0);
        nstall = 0;
        wlog.delete();
        set_mdu(1, 5'd8, 32'h8888);
        tick();
        chk("hog_pipe_data", rf_wdata, 32'h11);
        set_mdu(1, 5'd9, 32'h9999);
        tick();
        set_mdu(0, '0, '0);
        chk("full_ready", 32'(mdu_ready), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("starve_stalls", 32'(nstall), 32'd2);
        chk("starve_writes", 32'(wlog.size()), 32'd14);
        mdu_seen.delete();
        foreach (wlog[i]) if (wlog[i] != 5'd3) mdu_seen.push_back(wlog[i]);
        chk("starve_mdu_cnt", 32'(mdu_seen.size()), 32'd2);
        if (mdu_seen.size() == 2) begin
            chk("starve_first", 32'(mdu_seen[0]), 32'd8);
            chk("starve_second", 32'(mdu_seen[1]), 32'd9);
        end

        // Full FIFO popped while a new result waits
        wlog.delete();
        set_mdu(1, 5'd10, 32'hA);
        tick();
        set_mdu(1, 5'd11, 32'hB);
        tick();
        set_pipe(0, '0, '0, '0, '0, '0);
        set_mdu(1, 5'd12, 32'hC);
        chk("full_pop_ready", 32'(mdu_ready), 32'd0);
        tick();
        chk("after_pop_ready", 32'(mdu_ready), 32'd1);
        tick();
        set_mdu(0, '0, '0);
        for (int i = 0; i < 4; i++) tick();
        mdu_seen.delete();
        foreach (wlog[i]) if (wlog[i] >= 5'd10) mdu_seen.push_back(wlog[i]);
        chk("fullpop_cnt", 32'(mdu_seen.size()), 32'd3);
        if (mdu_seen.size() == 3) begin
            chk("fullpop_0", 32'(mdu_seen[0]), 32'd10);
            chk("fullpop_1", 32'(mdu_seen[1]), 32'd11);
            chk("fullpop_2", 32'(mdu_seen[2]), 32'd12);
        end

        // Async reset with an entry buffered
        set_pipe(1, 5'd4, 2'd1, '0, 32'h44, '0);
        set_mdu(1, 5'd13, 32'h1313);
        tick();
        set_mdu(0, '0, '0);
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_we", 32'(rf_we), 32'd0);
        chk("async_addr", 32'(rf_waddr), 32'd0);
        chk("async_data", rf_wdata, 32'd0);
        model_reset();
        set_pipe(0, '0, '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        wlog.delete();
        for (int i = 0; i < 10; i++) tick();
        hits = 0;
        foreach (wlog[i]) if (wlog[i] == 5'd13) hits++;
        chk("no_stale", 32'(hits), 32'd0);
        chk("no_writes", 32'(wlog.size()), 32'd0);

        // Writes to x0
        set_pipe(1, 5'd0, 2'd1, '0, 32'h55, '0);
        tick();
`ifdef WB_X0_FILTER_EN
        chk("x0_we", 32'(rf_we), 32'd0);
`else
        chk("x0_we", 32'(rf_we), 32'd1);
        chk("x0_addr", 32'(rf_waddr), 32'd0);
        chk("x0_data", rf_wdata, 32'h55);
`endif
        set_pipe(0, '0, '0, '0, '0, '0);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
